// File: rtl/seven_seg_scan_decoder.sv
// seven_seg_scan_decoder
// Watches the active-low anode strobes and segment lines of a four-digit
// multiplexed 7-segment driver and rebuilds the displayed hex value.
// A digit is sampled once its an/seg value has been stable for SETTLE_CYCLES
// cycles. When all four digits have been captured, the frame is published
// together with a one-cycle frame_valid pulse.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   an3..an0              anode strobes, active-low (an3 = most significant)
//   a..g, dp              segment lines and decimal point, active-low
//   digits[15:0]          captured frame, [15:12] = an3 digit
//   dp_flags[3:0]         decimal point lit per digit, bit i = an i
//   blank_flags[3:0]      digit sampled with every segment off
//   frame_valid           one-cycle pulse when the outputs are refreshed
//   frame_err             frame contained a bad pattern or a multi-anode sample
module seven_seg_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        an3,
  input  logic        an2,
  input  logic        an1,
  input  logic        an0,
  input  logic        a,
  input  logic        b,
  input  logic        c,
  input  logic        d,
  input  logic        e,
  input  logic        f,
  input  logic        g,
  input  logic        dp,
  output logic [15:0] digits,
  output logic [3:0]  dp_flags,
  output logic [3:0]  blank_flags,
  output logic        frame_valid,
  output logic        frame_err
);

  localparam logic [7:0] SETTLE    = SETTLE_CYCLES[7:0];
  localparam logic [7:0] SETTLE_M1 = SETTLE - 8'd1;

  // Lit-segment pattern (a in bit 6 .. g in bit 0) to {recognised, nibble}.
  function automatic logic [4:0] seg_decode(input logic [6:0] lit);
    case (lit)
      7'h7E:   seg_decode = {1'b1, 4'h0};
      7'h30:   seg_decode = {1'b1, 4'h1};
      7'h6D:   seg_decode = {1'b1, 4'h2};
      7'h79:   seg_decode = {1'b1, 4'h3};
      7'h33:   seg_decode = {1'b1, 4'h4};
      7'h5B:   seg_decode = {1'b1, 4'h5};
      7'h5F:   seg_decode = {1'b1, 4'h6};
      7'h70:   seg_decode = {1'b1, 4'h7};
      7'h7F:   seg_decode = {1'b1, 4'h8};
      7'h7B:   seg_decode = {1'b1, 4'h9};
      7'h77:   seg_decode = {1'b1, 4'hA};
      7'h1F:   seg_decode = {1'b1, 4'hB};
      7'h4E:   seg_decode = {1'b1, 4'hC};
      7'h3D:   seg_decode = {1'b1, 4'hD};
      7'h4F:   seg_decode = {1'b1, 4'hE};
      7'h47:   seg_decode = {1'b1, 4'hF};
      default: seg_decode = 5'b0_0000;
    endcase
  endfunction

  // in_q layout: {an3, an2, an1, an0, a, b, c, d, e, f, g, dp}
  logic [11:0] in_q, prev_q;
  logic [7:0]  stab_q, stab_d;
  logic [15:0] shadow_dig_q, shadow_dig_d;
  logic [3:0]  shadow_dp_q, shadow_dp_d;
  logic [3:0]  shadow_blank_q, shadow_blank_d;
  logic [3:0]  mask_q, mask_d;
  logic        err_acc_q, err_acc_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  dp_flags_q, dp_flags_d;
  logic [3:0]  blank_flags_q, blank_flags_d;
  logic        frame_valid_q, frame_valid_d;
  logic        frame_err_q, frame_err_d;

  logic        sample_s;
  logic [3:0]  an_low_s;
  logic        one_hot_s;
  logic        multi_s;
  logic [1:0]  idx_s;
  logic [6:0]  lit_s;
  logic        blank_s;
  logic [4:0]  dec_s;
  logic        pat_err_s;
  logic [3:0]  nib_s;
  logic [3:0]  mask_next_s;

  // Stability counter: clears on any change, saturates at SETTLE.
  always_comb begin
    stab_d = stab_q;
    if (in_q != prev_q) begin
      stab_d = 8'd0;
    end else if (stab_q < SETTLE) begin
      stab_d = stab_q + 8'd1;
    end else begin
      stab_d = stab_q;
    end
  end

  // Sample fires only on the SETTLE-1 -> SETTLE step, so once per activation.
  assign sample_s  = (in_q == prev_q) && (stab_q == SETTLE_M1);
  assign an_low_s  = ~in_q[11:8];
  assign one_hot_s = (an_low_s != 4'b0000) && ((an_low_s & (an_low_s - 4'd1)) == 4'b0000);
  assign multi_s   = (an_low_s != 4'b0000) && !one_hot_s;
  assign lit_s     = ~in_q[7:1];
  assign blank_s   = (lit_s == 7'b000_0000);
  assign dec_s     = seg_decode(lit_s);
  assign pat_err_s = !blank_s && !dec_s[4];
  assign nib_s     = dec_s[4] ? dec_s[3:0] : 4'h0;

  // Anode index of the single active strobe.
  always_comb begin
    case (an_low_s)
      4'b0001: idx_s = 2'd0;
      4'b0010: idx_s = 2'd1;
      4'b0100: idx_s = 2'd2;
      4'b1000: idx_s = 2'd3;
      default: idx_s = 2'd0;
    endcase
  end

  assign mask_next_s = mask_q | (4'b0001 << idx_s);

  // Frame assembly: store the sampled digit, publish when all four are present.
  always_comb begin
    shadow_dig_d   = shadow_dig_q;
    shadow_dp_d    = shadow_dp_q;
    shadow_blank_d = shadow_blank_q;
    mask_d         = mask_q;
    err_acc_d      = err_acc_q;
    digits_d       = digits_q;
    dp_flags_d     = dp_flags_q;
    blank_flags_d  = blank_flags_q;
    frame_err_d    = frame_err_q;
    frame_valid_d  = 1'b0;
    if (sample_s && multi_s) begin
      err_acc_d = 1'b1;
    end else if (sample_s && one_hot_s) begin
      shadow_dig_d[{idx_s, 2'b00} +: 4] = nib_s;
      shadow_dp_d[idx_s]                = ~in_q[0];
      shadow_blank_d[idx_s]             = blank_s;
      if (mask_next_s == 4'b1111) begin
        // Publish includes the digit sampled on this very edge.
        digits_d      = shadow_dig_d;
        dp_flags_d    = shadow_dp_d;
        blank_flags_d = shadow_blank_d;
        frame_err_d   = err_acc_q | pat_err_s;
        frame_valid_d = 1'b1;
        mask_d        = 4'b0000;
        err_acc_d     = 1'b0;
      end else begin
        mask_d    = mask_next_s;
        err_acc_d = err_acc_q | pat_err_s;
      end
    end else begin
      mask_d = mask_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_q           <= 12'hFFF;
      prev_q         <= 12'hFFF;
      stab_q         <= 8'd0;
      shadow_dig_q   <= 16'h0000;
      shadow_dp_q    <= 4'b0000;
      shadow_blank_q <= 4'b0000;
      mask_q         <= 4'b0000;
      err_acc_q      <= 1'b0;
      digits_q       <= 16'h0000;
      dp_flags_q     <= 4'b0000;
      blank_flags_q  <= 4'b0000;
      frame_valid_q  <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      in_q           <= {an3, an2, an1, an0, a, b, c, d, e, f, g, dp};
      prev_q         <= in_q;
      stab_q         <= stab_d;
      shadow_dig_q   <= shadow_dig_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_blank_q <= shadow_blank_d;
      mask_q         <= mask_d;
      err_acc_q      <= err_acc_d;
      digits_q       <= digits_d;
      dp_flags_q     <= dp_flags_d;
      blank_flags_q  <= blank_flags_d;
      frame_valid_q  <= frame_valid_d;
      frame_err_q    <= frame_err_d;
    end
  end

  assign digits      = digits_q;
  assign dp_flags    = dp_flags_q;
  assign blank_flags = blank_flags_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Testbench for seven_seg_scan_decoder: drives held an/seg values, a frame
// model computes expected frames from hold durations, and a monitor compares
// each frame_valid pulse against the queue of expected frames.
module tb_seven_seg_scan_decoder;

  localparam int S = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic an3, an2, an1, an0;
  logic a, b, c, d, e, f, g, dp;
  logic [15:0] digits;
  logic [3:0]  dp_flags, blank_flags;
  logic        frame_valid, frame_err;

  seven_seg_scan_decoder #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset),
    .an3(an3), .an2(an2), .an1(an1), .an0(an0),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp),
    .digits(digits), .dp_flags(dp_flags), .blank_flags(blank_flags),
    .frame_valid(frame_valid), .frame_err(frame_err)
  );

  typedef struct {
    logic [15:0] dig;
    logic [3:0]  dpf;
    logic [3:0]  blk;
    logic        err;
  } frame_t;

  frame_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Lit-segment patterns for hex 0..F, a in bit 6 .. g in bit 0.
  logic [6:0] pat [16];

  // Model state: the partial frame being collected.
  logic [3:0] m_dig [4];
  logic       m_dp  [4];
  logic       m_blk [4];
  logic       m_have [4];
  logic       m_err;
  logic [11:0] last_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_dig[i] = 4'h0; m_dp[i] = 1'b0; m_blk[i] = 1'b0; m_have[i] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  // One stable activation of (an_n, lit, dpl) as seen from the spec's rules.
  task automatic model_sample(input logic [3:0] an_n, input logic [6:0] lit, input logic dpl);
    int lows, idx, nib;
    logic bad, blank, all;
    frame_t fr;
    lows = 0; idx = 0;
    for (int i = 0; i < 4; i++) if (!an_n[i]) begin lows++; idx = i; end
    if (lows == 0) return;
    if (lows >= 2) begin m_err = 1'b1; return; end
    nib = 0; bad = 1'b0; blank = (lit == 7'd0);
    if (!blank) begin
      bad = 1'b1;
      for (int k = 0; k < 16; k++) if (pat[k] == lit) begin nib = k; bad = 1'b0; end
    end
    m_dig[idx] = nib[3:0]; m_dp[idx] = dpl; m_blk[idx] = blank; m_have[idx] = 1'b1;
    all = 1'b1;
    for (int i = 0; i < 4; i++) if (!m_have[i]) all = 1'b0;
    if (all) begin
      fr.dig = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
      fr.dpf = {m_dp[3], m_dp[2], m_dp[1], m_dp[0]};
      fr.blk = {m_blk[3], m_blk[2], m_blk[1], m_blk[0]};
      fr.err = m_err | bad;
      exp_q.push_back(fr);
      for (int i = 0; i < 4; i++) m_have[i] = 1'b0;
      m_err = 1'b0;
    end else begin
      m_err = m_err | bad;
    end
  endtask

  // Drive a value for n cycles; a hold of at least S+1 cycles yields one sample.
  task automatic hold(input logic [3:0] an_n, input logic [6:0] lit, input logic dpl, input int n);
    {an3, an2, an1, an0} = an_n;
    {a, b, c, d, e, f, g} = ~lit;
    dp = ~dpl;
    if (n >= S + 1) model_sample(an_n, lit, dpl);
    last_val = {an_n, ~lit, ~dpl};
    repeat (n) @(negedge clk);
  endtask

  task automatic frame4(input int h3, input int h2, input int h1, input int h0);
    hold(4'b0111, pat[h3], 1'b0, 10);
    hold(4'b1011, pat[h2], 1'b0, 10);
    hold(4'b1101, pat[h1], 1'b0, 10);
    hold(4'b1110, pat[h0], 1'b0, 10);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    {an3, an2, an1, an0, a, b, c, d, e, f, g, dp} = 12'hFFF;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    last_val = 12'hFFF;
    model_clear();
    check("rst_digits", {16'h0, digits}, 32'h0);
    check("rst_dp_flags", {28'h0, dp_flags}, 32'h0);
    check("rst_blank_flags", {28'h0, blank_flags}, 32'h0);
    check("rst_frame_valid", {31'h0, frame_valid}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
  endtask

  // Monitor: every frame_valid pulse pops one expected frame.
  frame_t got_f;
  logic fv_prev = 1'b0;
  always @(negedge clk) begin
    if (frame_valid) begin
      check("fv_back_to_back", {31'h0, fv_prev}, 32'h0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_frame: got digits %0h expected no frame", digits);
      end else begin
        got_f = exp_q.pop_front();
        check("digits", {16'h0, digits}, {16'h0, got_f.dig});
        check("dp_flags", {28'h0, dp_flags}, {28'h0, got_f.dpf});
        check("blank_flags", {28'h0, blank_flags}, {28'h0, got_f.blk});
        check("frame_err", {31'h0, frame_err}, {31'h0, got_f.err});
      end
    end
    fv_prev <= frame_valid;
  end

  initial begin
    logic [3:0] an_r;
    logic [6:0] lit_r;
    logic       dp_r;
    int         n_r, sel;

    pat = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
            7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    model_clear();
    reset = 1'b1;
    {an3, an2, an1, an0, a, b, c, d, e, f, g, dp} = 12'hFFF;
    repeat (3) @(negedge clk);
    do_reset();

    // Clean frame 1234.
    frame4(1, 2, 3, 4);

    // Short glitch "8" on an2, dp lit on an1.
    hold(4'b0111, pat[1], 1'b0, 10);
    hold(4'b1011, pat[8], 1'b0, 3);
    hold(4'b1011, pat[2], 1'b0, 10);
    hold(4'b1101, pat[3], 1'b1, 10);
    hold(4'b1110, pat[4], 1'b0, 10);

    // Unrecognised pattern (a,g) on an1, then clean ABCD.
    hold(4'b0111, pat[1], 1'b0, 10);
    hold(4'b1011, pat[2], 1'b0, 10);
    hold(4'b1101, 7'b100_0001, 1'b0, 10);
    hold(4'b1110, pat[4], 1'b0, 10);
    frame4(10, 11, 12, 13);

    // Two anodes low together, then FEEd; then blank on an0.
    hold(4'b1001, pat[8], 1'b0, 8);
    frame4(15, 14, 14, 13);
    hold(4'b0111, pat[1], 1'b0, 10);
    hold(4'b1011, pat[2], 1'b0, 10);
    hold(4'b1101, pat[3], 1'b0, 10);
    hold(4'b1110, 7'b000_0000, 1'b0, 10);

    // Settle boundary: S cycles is rejected, S+1 cycles is sampled.
    hold(4'b0111, pat[5], 1'b0, S);
    hold(4'b0111, pat[6], 1'b0, S + 1);
    hold(4'b1011, pat[7], 1'b1, S + 1);
    hold(4'b1101, pat[9], 1'b0, S);
    hold(4'b1101, pat[0], 1'b0, S + 1);
    hold(4'b1110, pat[3], 1'b0, S + 1);

    // Reset after three digits discards the partial frame.
    hold(4'b0111, pat[9], 1'b0, 10);
    hold(4'b1011, pat[8], 1'b0, 10);
    hold(4'b1101, pat[7], 1'b0, 10);
    hold(4'b1111, 7'b000_0000, 1'b0, 10);
    do_reset();
    hold(4'b1110, pat[6], 1'b0, 10);
    hold(4'b0111, pat[5], 1'b0, 10);
    hold(4'b1011, pat[4], 1'b0, 10);
    hold(4'b1101, pat[3], 1'b0, 10);

    // Randomised holds; consecutive values always differ.
    for (int t = 0; t < 400; t++) begin
      do begin
        sel = $urandom_range(99);
        if (sel < 75)      an_r = ~(4'b0001 << $urandom_range(3));
        else if (sel < 85) an_r = 4'b1111;
        else               an_r = 4'($urandom);
        sel = $urandom_range(99);
        if (sel < 60)      lit_r = pat[$urandom_range(15)];
        else if (sel < 75) lit_r = 7'b000_0000;
        else               lit_r = 7'($urandom);
        dp_r = 1'($urandom);
      end while ({an_r, ~lit_r, ~dp_r} == last_val);
      n_r = $urandom_range(9, 1);
      hold(an_r, lit_r, dp_r, n_r);
    end

    // Drain: let the last sample and any pending pulse appear.
    hold(4'b1111, 7'b000_0000, 1'b0, 1);
    if (last_val != 12'hFFF) hold(4'b1111, 7'b000_0000, 1'b0, 1);
    repeat (3 * S + 10) @(negedge clk);
    check("frames_outstanding", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_decoder.md
# seven_seg_scan_decoder

Receive-side counterpart of the four-digit multiplexed 7-segment LED driver: it watches the active-low anode strobes (an3..an0) and segment lines (a..g, dp) the driver produces, samples each digit once its strobe and pattern are stable, and decodes the pattern back to a hex nibble. When all four digits have been captured it presents a 16-bit frame with a one-cycle valid pulse. It sits in loopback benches and on-board self-check paths next to the driver, in the same clock domain.

## Interface
- SETTLE_CYCLES, 4: consecutive unchanged cycles of the registered an/seg value before a digit is sampled; legal range 1..255.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- an3, an2, an1, an0  in  1 each  anode strobes, active-low; an3 is the most significant digit.
- a, b, c, d, e, f, g  in  1 each  segment lines, active-low.
- dp  in  1  decimal point, active-low.
- digits  out  16  captured frame; [15:12]=an3 digit … [3:0]=an0 digit.
- dp_flags  out  4  captured dp per digit (1 = lit), bit i ↔ an i.
- blank_flags  out  4  1 = digit sampled with all a..g off.
- frame_valid  out  1  one-cycle pulse; digits/dp_flags/blank_flags/frame_err updated this cycle.
- frame_err  out  1  frame contained an unrecognised pattern or a multi-anode sample.

## Operation
- Input stage: all 12 inputs registered once (in_q); a second register (prev_q) holds the previous in_q. Both load all-ones on reset (all anodes and segments off).
- Stability counter stab (8 bit): clears when in_q ≠ prev_q, else increments, saturating at SETTLE_CYCLES. A sample event occurs on the edge where stab goes SETTLE_CYCLES-1 → SETTLE_CYCLES; exactly one sample per stable activation.
- Anode decode at sample: exactly one an low → digit index i; none low → ignored (no sample); two or more low → error sample, sets err_acc, no digit stored.
- Segment decode, lit segments (active-low inverted): 0 abcdef, 1 bc, 2 abdeg, 3 abcdg, 4 bcfg, 5 acdfg, 6 acdefg, 7 abc, 8 abcdefg, 9 abcdfg, A abcefg, b cdefg, C adef, d bcdeg, E adefg, F aefg. No segment lit → nibble 0, blank bit set. Any other pattern → nibble 0, err_acc set.
- Valid digit sample: nibble, dp and blank stored into slot i of a shadow frame; mask[i] set. Resampling a slot before the frame completes overwrites it (last value wins).
- Frame completion: on the sampling edge where mask becomes 4'b1111, shadow (including the current digit) is copied to digits/dp_flags/blank_flags, frame_err ← err_acc OR current error, frame_valid asserted; mask and err_acc cleared the same edge.
- Outputs other than frame_valid hold until the next completed frame.

## Timing
- Reset: digits=16'h0000, dp_flags=0, blank_flags=0, frame_valid=0, frame_err=0, mask=0, err_acc=0, stab=0, in_q=prev_q=all-ones. Reset asserted mid-frame discards the partial frame.
- Latency: input change presented before edge E0 appears in in_q after E0; sample edge is E0+SETTLE_CYCLES+1 if unchanged; frame_valid is high during the cycle after the sample edge of the completing digit.
- Glitch rejection: any an/seg value held fewer than SETTLE_CYCLES+1 cycles produces no sample.
- frame_valid never high two consecutive cycles (minimum 1+SETTLE_CYCLES cycles between samples).
- Simultaneous error and completion: frame still completes; frame_err=1.
- SETTLE_CYCLES=1: sample on second cycle of a new stable value.

## Test plan
- Reset, then drive an3..an0 low in turn with patterns 1,2,3,4 (dp off), 10 cycles each, SETTLE_CYCLES=4 → one frame_valid pulse after digit an0's sample, digits=16'h1234, dp_flags=0, blank_flags=0, frame_err=0.
- Same sequence with a 3-cycle glitch pattern "8" inserted on an2 before "2" and dp lit on an1 → digits=16'h1234, dp_flags=4'b0010, no extra sample.
- Digit an1 driven with lit segments a,g only → frame completes, digits[7:4]=0, frame_err=1; next clean frame 16'hABCD → frame_err=0.
- an2 and an1 low together for 8 cycles, then clean four digits "FEEd" → frame_err=1, digits=16'hFEED; all-segments-off on an0 in a further frame → blank_flags=4'b0001, digits[3:0]=0.
- Assert reset for one cycle after three digits captured → all outputs 0; next frame needs all four digits again before frame_valid.
- Loopback: FourDigitLEDdriver outputs wired to this block, button pulsed as in the driver bench → digits track the driver's displayed value each frame, frame_err never asserted.
